// File: rtl/tx_medida_if.sv
// Transmit request / serial status bundle between the measurement logic and tx_medida.
interface tx_medida_if;
  logic        partida;
  logic [15:0] medida;
  logic        saida_serial;
  logic        ocupado;
  logic        pronto;

  modport master (
    output partida,
    output medida,
    input  saida_serial,
    input  ocupado,
    input  pronto
  );

  modport slave (
    input  partida,
    input  medida,
    output saida_serial,
    output ocupado,
    output pronto
  );
endinterface

// File: rtl/tx_medida.sv
// 8N1 UART transmitter for a 16-bit measurement word, sent as high byte then low byte.
module tx_medida #(
  parameter int unsigned BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       reset,
  tx_medida_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      state_r,    state_s;
  logic        byte_idx_r, byte_idx_s;
  logic [2:0]  bit_cnt_r,  bit_cnt_s;
  logic [15:0] baud_cnt_r, baud_cnt_s;
  logic [15:0] hold_r,     hold_s;
  logic        line_r,     line_s;
  logic        busy_r,     busy_s;
  logic        done_r,     done_s;
  logic        baud_end_s;
  logic [7:0]  cur_byte_s;

  // next-state, datapath and next-output logic
  always_comb begin
    state_s    = state_r;
    byte_idx_s = byte_idx_r;
    bit_cnt_s  = bit_cnt_r;
    hold_s     = hold_r;
    line_s     = line_r;
    busy_s     = busy_r;
    done_s     = 1'b0;
    baud_end_s = (baud_cnt_r == BAUD_LAST);
    baud_cnt_s = baud_end_s ? 16'd0 : (baud_cnt_r + 16'd1);
    cur_byte_s = byte_idx_r ? hold_r[7:0] : hold_r[15:8];

    case (state_r)
      IDLE: begin
        baud_cnt_s = 16'd0;
        if (bus.partida) begin
          // acceptance edge: start bit goes out immediately
          hold_s     = bus.medida;
          byte_idx_s = 1'b0;
          bit_cnt_s  = 3'd0;
          line_s     = 1'b0;
          busy_s     = 1'b1;
          state_s    = START;
        end else begin
          line_s = 1'b1;
          busy_s = 1'b0;
        end
      end
      START: begin
        if (baud_end_s) begin
          bit_cnt_s = 3'd0;
          line_s    = cur_byte_s[0];
          state_s   = DATA;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (baud_end_s) begin
          if (bit_cnt_r == 3'd7) begin
            line_s  = 1'b1;
            state_s = STOP;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
            line_s    = cur_byte_s[bit_cnt_r + 3'd1];
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (baud_end_s) begin
          if (byte_idx_r == 1'b0) begin
            byte_idx_s = 1'b1;
            line_s     = 1'b0;
            state_s    = START;
          end else begin
            line_s  = 1'b1;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            state_s = IDLE;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        line_s     = 1'b1;
        busy_s     = 1'b0;
        baud_cnt_s = 16'd0;
        state_s    = IDLE;
      end
    endcase
  end

  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      byte_idx_r <= 1'b0;
      bit_cnt_r  <= 3'd0;
      baud_cnt_r <= 16'd0;
      hold_r     <= 16'd0;
      line_r     <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      byte_idx_r <= byte_idx_s;
      bit_cnt_r  <= bit_cnt_s;
      baud_cnt_r <= baud_cnt_s;
      hold_r     <= hold_s;
      line_r     <= line_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign bus.saida_serial = line_r;
  assign bus.ocupado      = busy_r;
  assign bus.pronto       = done_r;

endmodule

// File: tb/tb_tx_medida.sv
// Directed bench for tx_medida: table of frames at BAUD_DIV=4 plus reset, back-to-back and timing sequences.
module tb_tx_medida;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tx_medida_if bus4 ();
  tx_medida_if bus2 ();
  tx_medida_if bus7 ();

  tx_medida #(.BAUD_DIV(4)) u4 (.clk(clk), .reset(reset), .bus(bus4));
  tx_medida #(.BAUD_DIV(2)) u2 (.clk(clk), .reset(reset), .bus(bus2));
  tx_medida #(.BAUD_DIV(7)) u7 (.clk(clk), .reset(reset), .bus(bus7));

  typedef struct {
    logic [15:0] medida;
    logic [19:0] bits;   // first bit on the line is bits[19]
    string       name;
  } vec_t;

  // expected observation {saida_serial, ocupado, pronto}
  localparam logic [2:0] OBS_IDLE = 3'b100;
  localparam logic [2:0] OBS_DONE = 3'b101;

  localparam logic [19:0] BITS_01A5 = 20'b0100000001_0101001011;
  localparam logic [19:0] BITS_0000 = 20'b0000000001_0000000001;
  localparam logic [19:0] BITS_8001 = 20'b0000000011_0100000001;
  localparam logic [19:0] BITS_F800 = 20'b0000111111_0000000001;
  localparam logic [19:0] BITS_07FF = 20'b0111000001_0111111111;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic p, input logic [15:0] m);
    case (w)
      2: begin bus2.partida = p; bus2.medida = m; end
      7: begin bus7.partida = p; bus7.medida = m; end
      default: begin bus4.partida = p; bus4.medida = m; end
    endcase
  endtask

  function automatic logic [2:0] obs(input int w);
    case (w)
      2: return {bus2.saida_serial, bus2.ocupado, bus2.pronto};
      7: return {bus7.saida_serial, bus7.ocupado, bus7.pronto};
      default: return {bus4.saida_serial, bus4.ocupado, bus4.pronto};
    endcase
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s line/ocupado/pronto got=%b want=%b", name, act, exp);
    end
  endtask

  // Requests a frame on DUT w and checks every cycle up to and including the pronto cycle.
  task automatic run_frame(input int w, input int b, input logic [15:0] m, input logic [19:0] bits,
                           input logic hold, input int poke, input logic poke_p,
                           input logic [15:0] poke_m, input string name);
    drive(w, 1'b1, m);
    step();
    drive(w, hold, m);
    for (int c = 0; c < 20 * b; c++) begin
      chk($sformatf("%s c%0d", name, c), obs(w), {bits[19 - c / b], 1'b1, 1'b0});
      if (c == poke) drive(w, poke_p, poke_m);
      if (poke >= 0 && c == poke + 1) drive(w, hold, poke_m);
      step();
    end
    chk($sformatf("%s pronto", name), obs(w), OBS_DONE);
  endtask

  vec_t vecs [4];

  initial begin
    vecs[0] = '{16'h01A5, BITS_01A5, "frame_01A5"};
    vecs[1] = '{16'h0000, BITS_0000, "frame_0000"};
    vecs[2] = '{16'h8001, BITS_8001, "frame_8001"};
    vecs[3] = '{16'hF800, BITS_F800, "frame_F800"};

    reset = 1'b1;
    drive(4, 1'b0, 16'h0000);
    drive(2, 1'b0, 16'h0000);
    drive(7, 1'b0, 16'h0000);
    #1;
    chk("reset4", obs(4), OBS_IDLE);
    chk("reset2", obs(2), OBS_IDLE);
    chk("reset7", obs(7), OBS_IDLE);
    step();
    step();
    reset = 1'b0;
    step();
    chk("idle_after_reset", obs(4), OBS_IDLE);

    for (int i = 0; i < 4; i++) begin
      run_frame(4, 4, vecs[i].medida, vecs[i].bits, 1'b0, -1, 1'b0, vecs[i].medida, vecs[i].name);
      step();
      chk($sformatf("%s after", vecs[i].name), obs(4), OBS_IDLE);
    end

    // request at cycle 30 with a different word is ignored
    run_frame(4, 4, 16'h01A5, BITS_01A5, 1'b0, 30, 1'b1, 16'hFFFF, "ignored_req");
    for (int c = 0; c < 12; c++) begin
      step();
      chk($sformatf("ignored_req idle%0d", c), obs(4), OBS_IDLE);
    end

    // partida held high, medida changed mid-frame
    run_frame(4, 4, 16'hF800, BITS_F800, 1'b1, 40, 1'b1, 16'h07FF, "b2b_first");
    run_frame(4, 4, 16'h07FF, BITS_07FF, 1'b1, -1, 1'b1, 16'h07FF, "b2b_second");
    drive(4, 1'b0, 16'h07FF);
    step();
    chk("b2b after", obs(4), OBS_IDLE);

    // asynchronous reset mid-frame
    drive(4, 1'b1, 16'h1234);
    step();
    drive(4, 1'b0, 16'h1234);
    for (int c = 1; c <= 37; c++) step();
    #1;
    reset = 1'b1;
    #1;
    chk("midreset async", obs(4), OBS_IDLE);
    step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 90; c++) begin
      step();
      chk($sformatf("midreset nopronto%0d", c), obs(4), OBS_IDLE);
    end
    run_frame(4, 4, 16'h01A5, BITS_01A5, 1'b0, -1, 1'b0, 16'h01A5, "after_reset");
    step();
    chk("after_reset idle", obs(4), OBS_IDLE);

    // bit timing at other divisors
    run_frame(2, 2, 16'h01A5, BITS_01A5, 1'b0, -1, 1'b0, 16'h01A5, "baud2");
    step();
    chk("baud2 idle", obs(2), OBS_IDLE);
    run_frame(7, 7, 16'hF800, BITS_F800, 1'b0, -1, 1'b0, 16'hF800, "baud7");
    step();
    chk("baud7 idle", obs(7), OBS_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_medida.md
TX_MEDIDA -- requirements
Module: tx_medida

Interface
REQ-001 Parameter BAUD_DIV, default 5208, clock cycles per serial bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port reset  input  1  reset, asynchronous and active-high.
REQ-004 Port partida  input  1  transmit request, sampled on the rising edge of clk.
REQ-005 Port medida  input  16  measurement word from the measurement register, sampled only when a request is accepted.
REQ-006 Port saida_serial  output  1  serial line, idle high, 8N1 framing.
REQ-007 Port ocupado  output  1  high while a frame is in progress.
REQ-008 Port pronto  output  1  one-cycle pulse marking transmission complete.
REQ-009 All outputs SHALL be driven directly from flip-flops.

Function
REQ-010 The FSM SHALL have the states IDLE, START, DATA, STOP, with an internal byte index of 0 or 1.
REQ-011 In IDLE, partida=1 on an edge SHALL latch medida into a 16-bit holding register, clear the byte index and bit counters, and enter START.
REQ-012 partida SHALL be ignored in every state other than IDLE; the holding register SHALL NOT change mid-frame.
REQ-013 Byte 0 SHALL be medida[15:8] and byte 1 SHALL be medida[7:0], sent back-to-back with no idle gap.
REQ-014 Each byte SHALL consist of a start bit (0), 8 data bits LSB first, and a stop bit (1), for 10 bit periods.
REQ-015 Each bit period SHALL last exactly BAUD_DIV clk cycles, timed by a baud counter that runs 0..BAUD_DIV-1 and clears on each bit boundary.
REQ-016 saida_serial SHALL go low on the edge that accepts partida, giving a latency of 1 edge.
REQ-017 A whole transmission SHALL last 20*BAUD_DIV cycles.
REQ-018 START to DATA: after BAUD_DIV cycles; the first data bit is driven on that edge.
REQ-019 DATA to STOP: after the 8th bit period completes; saida_serial=1 is driven on that edge.
REQ-020 STOP, byte index 0: after BAUD_DIV cycles, increment the index and return to START.
REQ-021 STOP, byte index 1: after BAUD_DIV cycles, go to IDLE.
REQ-022 ocupado SHALL be set on the accepting edge and cleared on the edge that returns the FSM to IDLE.
REQ-023 pronto SHALL be set on that same edge and SHALL remain high for exactly one cycle.
REQ-024 partida=1 during the pronto cycle SHALL be accepted, because the FSM is in IDLE; the next frame then starts without an idle bit.
REQ-025 partida held high continuously SHALL produce back-to-back transmissions, each latching the medida value present at its accepting edge.
REQ-026 medida=16'h0000 (an empty measurement register) SHALL be transmitted like any other value, with no suppression.
REQ-027 The baud counter SHALL be wide enough for BAUD_DIV-1 and SHALL NOT wrap within a bit period.

Reset
REQ-028 reset=1 SHALL immediately, without waiting for clk, force IDLE, saida_serial=1, ocupado=0 and pronto=0, and clear the holding register, byte index, bit count and baud counter.
REQ-029 Reset mid-frame SHALL abort the frame; no pronto pulse is produced for the aborted frame.
REQ-030 After reset deasserts, the first partida SHALL start a complete fresh frame.

Verification (BAUD_DIV=4)
REQ-031 Basic frame: medida=16'h01A5, 1-cycle partida.
- saida_serial, per 4-cycle bit: 0,1,0,0,0,0,0,0,0,1 then 0,1,0,1,0,0,1,0,1,1.
- ocupado high for 80 cycles; pronto high for 1 cycle, on the 80th edge after acceptance.
REQ-032 Ignored request: partida pulsed again at cycle 30 with medida=16'hFFFF -> line matches REQ-031 exactly, and no second frame follows.
REQ-033 Back-to-back: partida held high, medida=16'hF800 then 16'h07FF changed mid-frame.
- First frame sends F8,00.
- Second frame starts on the pronto edge with no high gap and sends 07,FF.
REQ-034 Mid-frame reset: reset asserted asynchronously between edges at cycle 37, held 2 cycles.
- saida_serial=1 and ocupado=0 before the next edge.
- No pronto pulse appears; a subsequent partida yields a correct full frame.
REQ-035 Zero word: medida=16'h0000 -> 20 bits: 0,eight 0s,1,0,eight 0s,1; pronto pulses once.
REQ-036 Bit timing: with BAUD_DIV=2 and then 7, every line transition falls exactly on a multiple of BAUD_DIV cycles after the accepting edge.
